// File: rtl/pid_sat_core_if.sv
`default_nettype none
// ============================================================================
// Module      : pid_sat_core_if
// Description : Sample/result handshake bundle between the sensor path,
//               the PID core and the actuator drive.
// Revision    : 1.0  initial release
// ============================================================================
interface pid_sat_core_if #(
    parameter int DW = 16,
    parameter int OW = 32
);
    logic        [DW-1:0] Kp_in;
    logic        [DW-1:0] Ki_in;
    logic        [DW-1:0] Kd_in;
    logic        [DW-1:0] SV_in;
    logic        [DW-1:0] PV_in;
    logic                 in_valid;
    logic                 in_ready;
    logic                 clr;
    logic signed [OW-1:0] MV;
    logic                 mv_valid;
    logic        [3:0]    of;

    modport master (
        output Kp_in, Ki_in, Kd_in, SV_in, PV_in, in_valid, clr,
        input  in_ready, MV, mv_valid, of
    );

    modport slave (
        input  Kp_in, Ki_in, Kd_in, SV_in, PV_in, in_valid, clr,
        output in_ready, MV, mv_valid, of
    );
endinterface
`default_nettype wire

// File: rtl/pid_sat_core.sv
`default_nettype none
// ============================================================================
// Module      : pid_sat_core
// Description : Handshaked PID controller with one shared multiplier,
//               integrator anti-windup, output saturation and sticky flags.
// Revision    : 1.0  initial release
// ============================================================================
module pid_sat_core #(
    parameter int DW    = 16,
    parameter int OW    = 32,
    parameter int FRAC  = 0,
    parameter int I_LIM = 1000
) (
    input  logic               clk,
    input  logic               rst,
    pid_sat_core_if.slave      bus
);
    localparam int MW = OW + DW + 1;
    // Wide enough that the sum of all three products can never wrap.
    localparam int AW = OW + 2 * DW + 4;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ERR  = 3'd1;
    localparam logic [2:0] S_MP   = 3'd2;
    localparam logic [2:0] S_MI   = 3'd3;
    localparam logic [2:0] S_MD   = 3'd4;
    localparam logic [2:0] S_OUT  = 3'd5;

    localparam logic signed [OW-1:0] c_ILIM     = OW'(I_LIM);
    localparam logic signed [OW:0]   c_ILIM_POS = {1'b0, c_ILIM};
    localparam logic signed [OW:0]   c_ILIM_NEG = -c_ILIM_POS;
    localparam logic signed [AW-1:0] c_OUT_MAX  = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] c_OUT_MIN  = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic        [2:0]    r_state;
    logic        [DW-1:0] r_sv, r_pv, r_kp, r_ki, r_kd;
    logic signed [DW:0]   r_e, r_e_prev;
    logic signed [DW+1:0] r_de;
    logic                 r_e_prev_valid;
    logic signed [OW-1:0] r_integ;
    logic                 r_iclamp;
    logic signed [AW-1:0] r_acc;
    logic signed [OW-1:0] r_mv;
    logic                 r_mv_valid;
    logic        [3:0]    r_of;

    logic signed [DW:0]   w_e;
    logic signed [DW+1:0] w_de;
    logic signed [OW:0]   w_isum;
    logic signed [OW-1:0] w_integ_next;
    logic                 w_iclamp;
    logic signed [DW:0]   w_mul_a;
    logic signed [OW-1:0] w_mul_b;
    logic signed [MW-1:0] w_prod;
    logic signed [AW-1:0] w_acc_next;
    logic signed [AW-1:0] w_shift;
    logic                 w_hi, w_lo;
    logic signed [OW-1:0] w_sat;

    assign w_e    = $signed({1'b0, r_sv}) - $signed({1'b0, r_pv});
    assign w_de   = r_e_prev_valid ? ({w_e[DW], w_e} - {r_e_prev[DW], r_e_prev}) : '0;
    assign w_isum = {r_integ[OW-1], r_integ} + {{(OW-DW){w_e[DW]}}, w_e};

    always_comb begin
        w_iclamp     = 1'b0;
        w_integ_next = w_isum[OW-1:0];
        if (w_isum > c_ILIM_POS) begin
            w_iclamp     = 1'b1;
            w_integ_next = c_ILIM;
        end else if (w_isum < c_ILIM_NEG) begin
            w_iclamp     = 1'b1;
            w_integ_next = -c_ILIM;
        end
    end

    // Shared multiplier: gain operand is zero-extended, signal operand sign-extended.
    always_comb begin
        w_mul_a = {1'b0, r_kd};
        w_mul_b = {{(OW-DW-2){r_de[DW+1]}}, r_de};
        case (r_state)
            S_MP: begin
                w_mul_a = {1'b0, r_kp};
                w_mul_b = {{(OW-DW-1){r_e[DW]}}, r_e};
            end
            S_MI: begin
                w_mul_a = {1'b0, r_ki};
                w_mul_b = r_integ;
            end
            default: ;
        endcase
    end

    assign w_prod     = MW'(w_mul_a) * MW'(w_mul_b);
    assign w_acc_next = r_acc + {{(AW-MW){w_prod[MW-1]}}, w_prod};
    assign w_shift    = r_acc >>> FRAC;
    assign w_hi       = (w_shift > c_OUT_MAX);
    assign w_lo       = (w_shift < c_OUT_MIN);
    assign w_sat      = w_hi ? {1'b0, {(OW-1){1'b1}}} :
                        w_lo ? {1'b1, {(OW-1){1'b0}}} : w_shift[OW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_sv           <= '0;
            r_pv           <= '0;
            r_kp           <= '0;
            r_ki           <= '0;
            r_kd           <= '0;
            r_e            <= '0;
            r_e_prev       <= '0;
            r_de           <= '0;
            r_e_prev_valid <= 1'b0;
            r_integ        <= '0;
            r_iclamp       <= 1'b0;
            r_acc          <= '0;
            r_mv           <= '0;
            r_mv_valid     <= 1'b0;
            r_of           <= '0;
        end else begin
            r_mv_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.clr) begin
                        r_integ        <= '0;
                        r_e_prev_valid <= 1'b0;
                        r_of[3]        <= 1'b0;
                    end else if (bus.in_valid) begin
                        r_sv    <= bus.SV_in;
                        r_pv    <= bus.PV_in;
                        r_kp    <= bus.Kp_in;
                        r_ki    <= bus.Ki_in;
                        r_kd    <= bus.Kd_in;
                        r_state <= S_ERR;
                    end
                end
                S_ERR: begin
                    r_e            <= w_e;
                    r_de           <= w_de;
                    r_integ        <= w_integ_next;
                    r_iclamp       <= w_iclamp;
                    r_e_prev       <= w_e;
                    r_e_prev_valid <= 1'b1;
                    r_acc          <= '0;
                    r_state        <= S_MP;
                end
                S_MP: begin
                    r_acc   <= w_acc_next;
                    r_state <= S_MI;
                end
                S_MI: begin
                    r_acc   <= w_acc_next;
                    r_state <= S_MD;
                end
                S_MD: begin
                    r_acc   <= w_acc_next;
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    r_mv       <= w_sat;
                    r_mv_valid <= 1'b1;
                    r_of       <= {r_of[3] | w_hi | w_lo | r_iclamp, w_lo, w_hi, r_iclamp};
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready = (r_state == S_IDLE) & ~bus.clr & ~rst;
    assign bus.MV       = r_mv;
    assign bus.mv_valid = r_mv_valid;
    assign bus.of       = r_of;
endmodule
`default_nettype wire
